// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch-flush
// bubble insertion and saturating stall/flush event counters.
module id_ex_hazard_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegDst_i,
  input  logic                  BranchEQ_i,
  input  logic                  BranchNE_i,
  input  logic                  MemRead_i,
  input  logic                  MemtoReg_i,
  input  logic                  MemWrite_i,
  input  logic                  ALUSrc_i,
  input  logic                  RegWrite_i,
  input  logic [3:0]            ALUOp_i,
  input  logic [4:0]            rs_i,
  input  logic [4:0]            rt_i,
  input  logic [4:0]            rd_i,
  input  logic [DATA_WIDTH-1:0] read_data_1_i,
  input  logic [DATA_WIDTH-1:0] read_data_2_i,
  input  logic [DATA_WIDTH-1:0] imm_i,
  input  logic [DATA_WIDTH-1:0] pc_plus4_i,
  input  logic                  flush_i,
  input  logic                  clear_counters_i,
  output logic                  RegDst_o,
  output logic                  BranchEQ_o,
  output logic                  BranchNE_o,
  output logic                  MemRead_o,
  output logic                  MemtoReg_o,
  output logic                  MemWrite_o,
  output logic                  ALUSrc_o,
  output logic                  RegWrite_o,
  output logic [3:0]            ALUOp_o,
  output logic [4:0]            rs_o,
  output logic [4:0]            rt_o,
  output logic [4:0]            rd_o,
  output logic [DATA_WIDTH-1:0] read_data_1_o,
  output logic [DATA_WIDTH-1:0] read_data_2_o,
  output logic [DATA_WIDTH-1:0] imm_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o,
  output logic                  pc_write_o,
  output logic                  ifid_write_o,
  output logic [CNT_WIDTH-1:0]  stall_count_o,
  output logic [CNT_WIDTH-1:0]  flush_count_o
);

  typedef struct packed {
    logic       reg_dst;
    logic       branch_eq;
    logic       branch_ne;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [3:0] alu_op;
  } ctrl_t;

  ctrl_t                 ctrl_in, ctrl_d, ctrl_q;
  logic [4:0]            rs_q, rt_q, rd_q;
  logic [DATA_WIDTH-1:0] rd1_q, rd2_q, imm_q, pc4_q;
  logic [CNT_WIDTH-1:0]  stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;
  logic                  hazard, stall, bubble;

  assign ctrl_in = '{reg_dst: RegDst_i, branch_eq: BranchEQ_i, branch_ne: BranchNE_i,
                     mem_read: MemRead_i, mem_to_reg: MemtoReg_i, mem_write: MemWrite_i,
                     alu_src: ALUSrc_i, reg_write: RegWrite_i, alu_op: ALUOp_i};

  // Load in EX whose destination feeds either ID source; flush wins over stall.
  always_comb begin
    hazard = ctrl_q.mem_read && (rt_q != 5'd0) && ((rt_q == rs_i) || (rt_q == rt_i));
    stall  = hazard && !flush_i;
    bubble = stall || flush_i;
    ctrl_d = bubble ? ctrl_t'('0) : ctrl_in;
  end

  assign pc_write_o   = !stall;
  assign ifid_write_o = !stall;

  // Saturating event counters; clear overrides any increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (clear_counters_i) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall && (stall_cnt_q != '1))   stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
      if (flush_i && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
    end
  end

  // Pipeline register: control may be bubbled, data fields always advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q      <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      imm_q       <= '0;
      pc4_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      rs_q        <= rs_i;
      rt_q        <= rt_i;
      rd_q        <= rd_i;
      rd1_q       <= read_data_1_i;
      rd2_q       <= read_data_2_i;
      imm_q       <= imm_i;
      pc4_q       <= pc_plus4_i;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign RegDst_o      = ctrl_q.reg_dst;
  assign BranchEQ_o    = ctrl_q.branch_eq;
  assign BranchNE_o    = ctrl_q.branch_ne;
  assign MemRead_o     = ctrl_q.mem_read;
  assign MemtoReg_o    = ctrl_q.mem_to_reg;
  assign MemWrite_o    = ctrl_q.mem_write;
  assign ALUSrc_o      = ctrl_q.alu_src;
  assign RegWrite_o    = ctrl_q.reg_write;
  assign ALUOp_o       = ctrl_q.alu_op;
  assign rs_o          = rs_q;
  assign rt_o          = rt_q;
  assign rd_o          = rd_q;
  assign read_data_1_o = rd1_q;
  assign read_data_2_o = rd2_q;
  assign imm_o         = imm_q;
  assign pc_plus4_o    = pc4_q;
  assign stall_count_o = stall_cnt_q;
  assign flush_count_o = flush_cnt_q;

endmodule
